card_deal_fsm: RTL and testbench

CARD_DEAL_FSM -- requirements
Module: card_deal_fsm

---
 rtl/card_deal_fsm.sv | 100 ++++++++++
 tb/tb_card_deal_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/card_deal_fsm.sv
// Two-card-plus-third-card deal sequencer: walks the six card slots, applies the
// third-card drawing rules, and reports the winner once the hand is complete.
module card_deal_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic [3:0] new_card,
  output logic [5:0] load,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [2:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DEAL_P3, DEAL_D3, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] card_q, card_d;
  logic [3:0] v;
  logic       dealer_draw;
  logic       natural;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DEAL_P1;
      card_q  <= 4'd1;
    end else begin
      state_q <= state_d;
      card_q  <= card_d;
    end
  end

  // Any out-of-range count snaps back to 1 so the counter can never stick.
  assign card_d   = (card_q >= 4'd13) ? 4'd1 : card_q + 4'd1;
  assign new_card = card_q;

  // Face cards and tens count as zero for the dealer's third-card decision.
  assign v       = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

  always_comb begin
    dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (v != 4'd8);
      4'd4:             dealer_draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             dealer_draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             dealer_draw = (v >= 4'd6) && (v <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 6'b0;
    done       = 1'b0;
    player_win = 1'b0;
    dealer_win = 1'b0;
    if (!reset) begin
      case (state_q)
        DEAL_P1: if (step) begin load[0] = 1'b1; state_d = DEAL_D1; end
        DEAL_D1: if (step) begin load[1] = 1'b1; state_d = DEAL_P2; end
        DEAL_P2: if (step) begin load[2] = 1'b1; state_d = DEAL_D2; end
        DEAL_D2: if (step) begin load[3] = 1'b1; state_d = DEAL_P3; end
        DEAL_P3: begin
          if (step) begin
            if (natural) begin
              state_d = DONE;
            end else if (pscore <= 4'd5) begin
              load[4] = 1'b1;
              state_d = DEAL_D3;
            end else if (dscore <= 4'd5) begin
              load[5] = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DONE;
            end
          end
        end
        DEAL_D3: begin
          if (step) begin
            load[5] = dealer_draw;
            state_d = DONE;
          end
        end
        DONE: begin
          done       = 1'b1;
          player_win = (pscore >= dscore);
          dealer_win = (dscore >= pscore);
        end
        default: state_d = DEAL_P1;
      endcase
    end
  end

endmodule

// File: tb/tb_card_deal_fsm.sv
// Bench for card_deal_fsm: directed vector table plus randomized hands against a
// rule-level model of the deal.
module tb_card_deal_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic [3:0] new_card;
  logic [5:0] load;
  logic       done, player_win, dealer_win;

  always #5 clk = ~clk;

  card_deal_fsm dut (
    .clk(clk), .reset(reset), .step(step), .pscore(pscore), .dscore(dscore),
    .pcard3(pcard3), .new_card(new_card), .load(load), .done(done),
    .player_win(player_win), .dealer_win(dealer_win)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: which card slots have been filled this hand, whether the hand is over,
  // and the value the card counter should show.
  int dealt[$];
  bit m_over  = 1'b0;
  bit m_known = 1'b0;
  int m_card  = 1;

  function automatic bit dealer_draws(int ds, int pc3);
    int val;
    val = (pc3 >= 10) ? 0 : pc3;
    return (ds <= 2) || (ds == 3 && val != 8) || (ds == 4 && val >= 2 && val <= 7) ||
           (ds == 5 && val >= 4 && val <= 7) || (ds == 6 && val >= 6 && val <= 7);
  endfunction

  function automatic int m_load(bit rst, bit stp, int ps, int ds, int pc3);
    if (rst || !stp || m_over) return 0;
    if (dealt.size() < 4) return 1 << dealt.size();
    if (dealt[dealt.size()-1] == 4) return dealer_draws(ds, pc3) ? 32 : 0;
    if (ps >= 8 || ds >= 8) return 0;
    if (ps <= 5) return 16;
    if (ds <= 5) return 32;
    return 0;
  endfunction

  task automatic tick(input bit rst, input bit stp, input int ps, input int ds, input int pc3,
                      output logic [5:0] a_load, output logic a_done, output logic a_pw,
                      output logic a_dw, output logic [3:0] a_card);
    int el;
    bit ed, epw, edw, decide;
    @(negedge clk);
    reset = rst; step = stp;
    pscore = ps[3:0]; dscore = ds[3:0]; pcard3 = pc3[3:0];
    #1;
    el  = m_load(rst, stp, ps, ds, pc3);
    ed  = !rst && m_over;
    epw = ed && (ps >= ds);
    edw = ed && (ds >= ps);
    a_load = load; a_done = done; a_pw = player_win; a_dw = dealer_win; a_card = new_card;
    vectors++;
    if (load !== 6'(el) || done !== ed || player_win !== epw || dealer_win !== edw ||
        (m_known && new_card !== 4'(m_card))) begin
      miscompares++;
      $display("FAIL model t=%0t rst=%0b step=%0b ps=%0d ds=%0d pc3=%0d: got load=%b done=%b pw=%b dw=%b card=%0d, want load=%b done=%b pw=%b dw=%b card=%0d",
               $time, rst, stp, ps, ds, pc3, load, done, player_win, dealer_win, new_card,
               6'(el), ed, epw, edw, m_card);
    end
    @(posedge clk);
    if (rst) begin
      dealt.delete();
      m_over = 1'b0; m_card = 1; m_known = 1'b1;
    end else begin
      decide = stp && !m_over && dealt.size() >= 4;
      if (el != 0) dealt.push_back($clog2(el));
      if (decide && el != 16) m_over = 1'b1;
      m_card = (m_card % 13) + 1;
    end
  endtask

  typedef struct {
    bit rst, stp;
    int ps, ds, pc3, gap;
    int eload;
    bit edone, epw, edw;
    int ecard;  // 0 = not checked
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit stp, int ps, int ds, int pc3, int gap,
                              int eload, bit edone, bit epw, bit edw, int ecard);
    vec_t r;
    r.rst = rst; r.stp = stp; r.ps = ps; r.ds = ds; r.pc3 = pc3; r.gap = gap;
    r.eload = eload; r.edone = edone; r.epw = epw; r.edw = edw; r.ecard = ecard;
    tbl.push_back(r);
  endfunction

  function automatic void add_first_four();
    add(0,1,0,0,0,1, 1,0,0,0,0);
    add(0,1,0,0,0,1, 2,0,0,0,0);
    add(0,1,0,0,0,1, 4,0,0,0,0);
    add(0,1,0,0,0,1, 8,0,0,0,0);
  endfunction

  initial begin
    logic [5:0] al;
    logic ad, ap, aw;
    logic [3:0] ac;
    int ps, ds, pc3, guard;

    // Counter wrap: step right after reset, then 13 cycles after another reset.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add(0,1,0,0,0,1,  1,0,0,0,1);
    add(1,0,0,0,0,13, 0,0,0,0,0);
    add(0,1,0,0,0,1,  1,0,0,0,1);
    // Reset beats step; natural ends the hand; step ignored in DONE.
    add(1,1,0,0,0,1,  0,0,0,0,0);
    add_first_four();
    add(0,1,8,3,0,1,  0,0,0,0,0);
    add(0,0,8,3,0,0,  0,1,1,0,0);
    add(0,1,8,3,0,1,  0,1,1,0,0);
    // Player draws, dealer draws on 6 vs third card 6.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add_first_four();
    add(0,1,3,6,0,1,  16,0,0,0,0);
    add(0,1,3,6,6,1,  32,0,0,0,0);
    add(0,0,3,6,6,0,  0,1,0,1,0);
    // Player draws, dealer stands on 3 vs third card 8.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add_first_four();
    add(0,1,2,3,0,1,  16,0,0,0,0);
    add(0,1,2,3,8,1,  0,0,0,0,0);
    add(0,0,2,3,8,0,  0,1,0,1,0);
    // Both stand on 7: tie.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add_first_four();
    add(0,1,7,7,0,1,  0,0,0,0,0);
    add(0,0,7,7,0,0,  0,1,1,1,0);
    // Player stands on 6, dealer draws on 4 directly from DEAL_P3.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add_first_four();
    add(0,1,6,4,0,1,  32,0,0,0,0);
    add(0,0,6,4,0,0,  0,1,1,0,0);
    // Face-card third card counts as zero: dealer 5 vs 12 stands.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add_first_four();
    add(0,1,1,5,0,1,  16,0,0,0,0);
    add(0,1,1,5,12,1, 0,0,0,0,0);
    add(0,0,1,5,12,0, 0,1,0,1,0);
    // Reset after the P2 load restarts the hand at P1.
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add(0,1,0,0,0,1,  1,0,0,0,0);
    add(0,1,0,0,0,1,  2,0,0,0,0);
    add(0,1,0,0,0,1,  4,0,0,0,0);
    add(1,0,0,0,0,0,  0,0,0,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,1);
    add(0,1,0,0,0,1,  1,0,0,0,2);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].stp, tbl[i].ps, tbl[i].ds, tbl[i].pc3, al, ad, ap, aw, ac);
      vectors++;
      if (al !== 6'(tbl[i].eload) || ad !== tbl[i].edone || ap !== tbl[i].epw ||
          aw !== tbl[i].edw || (tbl[i].ecard != 0 && ac !== 4'(tbl[i].ecard))) begin
        miscompares++;
        $display("FAIL row %0d: got load=%b done=%b pw=%b dw=%b card=%0d, want load=%b done=%b pw=%b dw=%b card=%0d",
                 i, al, ad, ap, aw, ac, 6'(tbl[i].eload), tbl[i].edone, tbl[i].epw,
                 tbl[i].edw, tbl[i].ecard);
      end
      for (int g = 0; g < tbl[i].gap; g++)
        tick(1'b0, 1'b0, tbl[i].ps, tbl[i].ds, tbl[i].pc3, al, ad, ap, aw, ac);
    end

    // Randomized hands with occasional mid-hand resets.
    for (int hand = 0; hand < 60; hand++) begin
      ps = $urandom_range(0, 9); ds = $urandom_range(0, 9); pc3 = $urandom_range(0, 13);
      tick(1'b1, $urandom_range(0, 1) == 1, ps, ds, pc3, al, ad, ap, aw, ac);
      guard = 0;
      while (!m_over && guard < 40) begin
        guard++;
        for (int g = $urandom_range(1, 3); g > 0; g--)
          tick(1'b0, 1'b0, ps, ds, pc3, al, ad, ap, aw, ac);
        ps = $urandom_range(0, 9); ds = $urandom_range(0, 9); pc3 = $urandom_range(0, 13);
        if ($urandom_range(0, 24) == 0)
          tick(1'b1, 1'b0, ps, ds, pc3, al, ad, ap, aw, ac);
        else
          tick(1'b0, 1'b1, ps, ds, pc3, al, ad, ap, aw, ac);
      end
      vectors++;
      if (!m_over) begin
        miscompares++;
        $display("FAIL hand %0d: hand never completed within %0d steps", hand, guard);
      end
      tick(1'b0, 1'b0, ps, ds, pc3, al, ad, ap, aw, ac);
      tick(1'b0, 1'b1, ps, ds, pc3, al, ad, ap, aw, ac);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
